// File: rtl/cache_pkg.sv
// Shared constants, FSM encoding and address helpers for the L1 miss sequencer.
package cache_pkg;
  localparam int TAG_W   = 19;
  localparam int INDEX_W = 11;
  localparam int OFF_W   = 2;

  localparam logic [31:0] LINE_MASK = ~32'((1 << OFF_W) - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2
  } state_t;

  function automatic logic [31:0] line_addr(input logic [31:0] addr);
    return addr & LINE_MASK;
  endfunction

  function automatic logic [TAG_W-1:0] addr_tag(input logic [31:0] line);
    return line[OFF_W+INDEX_W +: TAG_W];
  endfunction

  function automatic logic [31:0] mk_addr(input logic [TAG_W-1:0] tag,
                                          input logic [INDEX_W-1:0] index);
    return {tag, index, {OFF_W{1'b0}}};
  endfunction
endpackage

// File: rtl/cache_if.sv
// CPU / array / memory signal bundle; master is the controller, slave the environment.
interface cache_if #(parameter int CNT_W = 32);
  import cache_pkg::*;

  logic             cpu_req, cpu_we;
  logic [31:0]      cpu_addr;
  logic             hit0, hit1, lru;
  logic             victim_valid, victim_dirty;
  logic [TAG_W-1:0] victim_tag;
  logic             mem_ready;
  logic             stall, way_sel, data_we, fill_sel, tag_we;
  logic             dirty_set, dirty_clr, lru_we, lru_val;
  logic             mem_req, mem_we;
  logic [31:0]      mem_addr;
  logic [CNT_W-1:0] hit_count, miss_count;

  modport master (
    input  cpu_req, cpu_we, cpu_addr, hit0, hit1, lru,
           victim_valid, victim_dirty, victim_tag, mem_ready,
    output stall, way_sel, data_we, fill_sel, tag_we, dirty_set, dirty_clr,
           lru_we, lru_val, mem_req, mem_we, mem_addr, hit_count, miss_count
  );

  modport slave (
    output cpu_req, cpu_we, cpu_addr, hit0, hit1, lru,
           victim_valid, victim_dirty, victim_tag, mem_ready,
    input  stall, way_sel, data_we, fill_sel, tag_we, dirty_set, dirty_clr,
           lru_we, lru_val, mem_req, mem_we, mem_addr, hit_count, miss_count
  );
endinterface

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_count
);
  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        r_count <= '0;
    else if (i_inc && r_count != '1) r_count <= r_count + 1'b1;
  end

  assign o_count = r_count;
endmodule

// File: rtl/cache_ctrl.sv
// Write-back / write-allocate miss sequencer for the 2-way L1: hits resolve
// combinationally in IDLE, misses walk WRITEBACK (dirty victim) then ALLOCATE.
module cache_ctrl
  import cache_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic    CLK,
  input  logic    reset,
  cache_if.master bus
);
  state_t           r_state;
  logic [31:0]      r_line;
  logic [TAG_W-1:0] r_vtag;
  logic             r_victim, r_replay;
  logic             w_hit, w_miss, w_idle;

  assign w_hit  = bus.cpu_req & (bus.hit0 | bus.hit1);
  assign w_miss = bus.cpu_req & ~bus.hit0 & ~bus.hit1;
  assign w_idle = (r_state == IDLE);

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_line   <= '0;
      r_vtag   <= '0;
      r_victim <= 1'b0;
      r_replay <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (bus.cpu_req) begin
          r_replay <= 1'b0;
          if (w_miss) begin
            r_line   <= line_addr(bus.cpu_addr);
            r_vtag   <= bus.victim_tag;
            r_victim <= bus.lru;
            r_state  <= (bus.victim_valid & bus.victim_dirty) ? WRITEBACK : ALLOCATE;
          end
        end
        WRITEBACK: if (bus.mem_ready) r_state <= ALLOCATE;
        ALLOCATE: if (bus.mem_ready) begin
          r_state  <= IDLE;
          r_replay <= 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Mealy decode: hits and the fill strobe must land in the same cycle as
  // their trigger, and reset forces every output low immediately.
  always_comb begin
    bus.stall     = 1'b0;
    bus.way_sel   = 1'b0;
    bus.data_we   = 1'b0;
    bus.fill_sel  = 1'b0;
    bus.tag_we    = 1'b0;
    bus.dirty_set = 1'b0;
    bus.dirty_clr = 1'b0;
    bus.lru_we    = 1'b0;
    bus.lru_val   = 1'b0;
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    if (!reset) begin
      case (r_state)
        IDLE: begin
          if (w_hit) begin
            bus.way_sel   = bus.hit1;
            bus.data_we   = bus.cpu_we;
            bus.dirty_set = bus.cpu_we;
            bus.lru_we    = 1'b1;
            bus.lru_val   = ~bus.hit1;
          end else if (w_miss) begin
            bus.stall = 1'b1;
          end
        end
        WRITEBACK: begin
          bus.stall    = 1'b1;
          bus.mem_req  = 1'b1;
          bus.mem_we   = 1'b1;
          bus.mem_addr = mk_addr(r_vtag, r_line[OFF_W +: INDEX_W]);
        end
        ALLOCATE: begin
          bus.stall    = 1'b1;
          bus.mem_req  = 1'b1;
          bus.mem_addr = mk_addr(addr_tag(r_line), r_line[OFF_W +: INDEX_W]);
          if (bus.mem_ready) begin
            bus.way_sel   = r_victim;
            bus.data_we   = 1'b1;
            bus.fill_sel  = 1'b1;
            bus.tag_we    = 1'b1;
            bus.dirty_clr = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // The replayed lookup after a fill is the same access, so it is not a hit.
  sat_counter #(.CNT_W(CNT_W)) u_hit_cnt (
    .clk(CLK), .rst(reset), .i_inc(w_idle & w_hit & ~r_replay), .o_count(bus.hit_count)
  );

  sat_counter #(.CNT_W(CNT_W)) u_miss_cnt (
    .clk(CLK), .rst(reset), .i_inc(w_idle & w_miss), .o_count(bus.miss_count)
  );
endmodule

// File: tb/tb_cache_ctrl.sv
// Self-checking bench for cache_ctrl; memory transactions are scored through a queue.
module tb_cache_ctrl;
  localparam int CNT = 4;
  localparam int CMAX = (1 << CNT) - 1;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
  } mem_rec_t;

  logic CLK = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   exp_hits = 0;
  int   exp_miss = 0;
  mem_rec_t exp_q[$];

  always #5 CLK = ~CLK;

  cache_if #(.CNT_W(CNT)) bus ();

  cache_ctrl #(.CNT_W(CNT)) dut (.CLK(CLK), .reset(reset), .bus(bus));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int sat(input int v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  task automatic idle_inputs();
    bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = '0;
    bus.hit0 = 0; bus.hit1 = 0; bus.lru = 0;
    bus.victim_valid = 0; bus.victim_dirty = 0; bus.victim_tag = '0;
    bus.mem_ready = 0;
  endtask

  task automatic chk_counts(input string tag);
    chk({tag, "_hits"}, bus.hit_count, exp_hits);
    chk({tag, "_miss"}, bus.miss_count, exp_miss);
  endtask

  task automatic do_hit(input logic we, input logic [31:0] addr, input logic way);
    @(negedge CLK);
    bus.cpu_req = 1; bus.cpu_we = we; bus.cpu_addr = addr;
    bus.hit0 = ~way; bus.hit1 = way; bus.mem_ready = 0;
    #1;
    chk("hit_stall", bus.stall, 0);
    chk("hit_way", bus.way_sel, way);
    chk("hit_strobes", {bus.data_we, bus.fill_sel, bus.dirty_set, bus.tag_we},
        {we, 1'b0, we, 1'b0});
    chk("hit_lru", {bus.lru_we, bus.lru_val}, {1'b1, ~way});
    chk("hit_nomem", bus.mem_req, 0);
    exp_hits = sat(exp_hits);
    @(negedge CLK);
    bus.cpu_req = 0; bus.hit0 = 0; bus.hit1 = 0;
    #1 chk_counts("hit_cnt");
  endtask

  task automatic do_miss(input logic we, input logic [31:0] addr, input logic way,
                         input logic dirty, input logic [18:0] vtag,
                         input int wb_wait, input int fill_wait);
    mem_rec_t r;
    int waits;
    @(negedge CLK);
    bus.cpu_req = 1; bus.cpu_we = we; bus.cpu_addr = addr;
    bus.hit0 = 0; bus.hit1 = 0; bus.lru = way;
    bus.victim_valid = 1; bus.victim_dirty = dirty; bus.victim_tag = vtag;
    bus.mem_ready = 0;
    if (dirty) exp_q.push_back('{1'b1, {vtag, addr[12:2], 2'b00}});
    exp_q.push_back('{1'b0, {addr[31:2], 2'b00}});
    #1;
    chk("miss_stall", bus.stall, 1);
    chk("miss_nomem", bus.mem_req, 0);
    exp_miss = sat(exp_miss);
    while (exp_q.size() != 0) begin
      r = exp_q[0];
      waits = r.we ? wb_wait : fill_wait;
      for (int c = 0; c <= waits; c++) begin
        @(negedge CLK);
        bus.mem_ready = (c == waits);
        #1;
        chk("mem_req", bus.mem_req, 1);
        chk("mem_we", bus.mem_we, r.we);
        chk("mem_addr", bus.mem_addr, r.addr);
        chk("mem_stall", bus.stall, 1);
        if (r.we || c != waits)
          chk("no_arr_wr", {bus.data_we, bus.tag_we, bus.dirty_clr}, 0);
      end
      void'(exp_q.pop_front());
      if (!r.we)
        chk("fill_wr", {bus.data_we, bus.tag_we, bus.fill_sel, bus.dirty_clr, bus.way_sel},
            {4'b1111, way});
    end
    @(negedge CLK);
    bus.mem_ready = 0;
    if (way) bus.hit1 = 1; else bus.hit0 = 1;
    #1;
    chk("replay_stall", bus.stall, 0);
    chk("replay_wr", {bus.data_we, bus.dirty_set, bus.fill_sel, bus.way_sel},
        {we, we, 1'b0, way});
    chk("replay_lru", {bus.lru_we, bus.lru_val}, {1'b1, ~way});
    chk("replay_nomem", bus.mem_req, 0);
    @(negedge CLK);
    idle_inputs();
    #1 chk_counts("miss_cnt");
  endtask

  initial begin
    idle_inputs();
    reset = 1;
    #12;
    chk("rst_outs", {bus.stall, bus.mem_req, bus.data_we, bus.tag_we, bus.lru_we}, 0);
    chk_counts("rst");
    @(negedge CLK);
    reset = 0;

    do_hit(1'b0, 32'h0000_1004, 1'b1);
    do_miss(1'b0, 32'h0000_2008, 1'b0, 1'b0, 19'h0, 0, 3);
    do_miss(1'b1, 32'h0000_4008, 1'b1, 1'b1, 19'h00005, 2, 1);
    do_hit(1'b1, 32'h0000_3000, 1'b0);

    // mem_ready while idle must not start anything
    @(negedge CLK);
    bus.mem_ready = 1;
    @(negedge CLK);
    #1 chk("idle_rdy", {bus.mem_req, bus.stall}, 0);
    bus.mem_ready = 0;

    for (int i = 0; i < 16; i++) do_hit(i[0], 32'h0000_0100 + 32'(i * 4), i[1]);
    chk("hit_sat", bus.hit_count, CMAX);

    // async reset in the middle of a fill
    @(negedge CLK);
    bus.cpu_req = 1; bus.cpu_addr = 32'h0000_6010; bus.lru = 1;
    bus.victim_valid = 0;
    @(negedge CLK);
    #1 chk("pre_rst_req", bus.mem_req, 1);
    #2 reset = 1;
    #1;
    chk("rst_memreq", {bus.mem_req, bus.stall, bus.tag_we, bus.data_we}, 0);
    exp_hits = 0; exp_miss = 0;
    chk_counts("rst_mid");
    @(negedge CLK);
    idle_inputs();
    reset = 0;
    @(negedge CLK);
    bus.mem_ready = 1;
    #1 chk("post_rst_idle", {bus.mem_req, bus.stall}, 0);
    @(negedge CLK);
    #1 chk("post_rst_idle2", bus.mem_req, 0);
    bus.mem_ready = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
